// File: rtl/fetch_stage_pkg.sv
// Shared widths, constants and the {pc, inst} entry type for the fetch stage.
package fetch_stage_pkg;

  localparam int XLEN       = 32;
  localparam int ILEN_BYTES = 4;

  localparam logic [XLEN-1:0] NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(ILEN_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, inst} FIFO between the memory response port and decode.
module fetch_queue
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;
  logic         do_push;

  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush;
  // With two slots the write slot is the read slot offset by count modulo 2.
  assign wr_ptr  = rd_ptr ^ count[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // NOTE: the data array is not reset; count alone says which slots hold live entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    head = '{pc: '0, inst: NOP};
    if (!empty) head = mem[rd_ptr];
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, credit-limited imem requests, in-order response buffering, redirect flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  logic [31:0]  pc;
  logic [31:0]  resp_pc;
  logic [1:0]   outstanding;
  logic [1:0]   drop_cnt;
  logic [1:0]   q_count;
  logic         q_empty;
  fetch_entry_t q_head;
  logic         pop;
  logic         accept;
  logic         push;
  logic [2:0]   credit_used;

  assign id_valid = !q_empty;
  assign id_inst  = q_head.inst;
  assign id_pc    = q_head.pc;
  assign pop      = id_valid && id_ready;

  // Buffered plus in-flight words must fit the queue once this cycle's pop is taken.
  assign credit_used    = {1'b0, outstanding} + {1'b0, q_count} - {2'b00, pop};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < 3'd2);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = imem_resp_valid && !redirect_valid && (drop_cnt == 2'd0);

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
    end else if (redirect_valid) begin
      pc          <= word_align(redirect_pc);
      resp_pc     <= word_align(redirect_pc);
      outstanding <= outstanding - {1'b0, imem_resp_valid};
      drop_cnt    <= outstanding - {1'b0, imem_resp_valid};
    end else begin
      if (accept) pc <= pc + PC_STEP;
      outstanding <= outstanding + {1'b0, accept} - {1'b0, imem_resp_valid};
      if (imem_resp_valid) begin
        if (drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
        else                  resp_pc  <= resp_pc + PC_STEP;
      end
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: resp_pc, inst: imem_resp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (q_count),
    .head      (q_head),
    .empty     (q_empty)
  );

endmodule
